// File: rtl/mult_div_unit.sv
// Multi-cycle HI/LO unit: iterative shift-add multiply, restoring divide, mthi/mtlo.
// One operand bit per cycle; results land in HI/LO on a single done edge.
module mult_div_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             MDStart,
  input  logic [2:0]       MDOp,
  input  logic [WIDTH-1:0] MDOpX,
  input  logic [WIDTH-1:0] MDOpY,
  output logic             MDBusy,
  output logic             MDDone,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam logic [2:0] OpNone = 3'd0;
  localparam logic [2:0] OpMult = 3'd1;
  localparam logic [2:0] OpDiv  = 3'd3;
  localparam logic [2:0] OpDivu = 3'd4;
  localparam logic [2:0] OpMthi = 3'd5;
  localparam logic [2:0] OpMtlo = 3'd6;
  localparam logic [2:0] OpRsvd = 3'd7;

  localparam logic [CNT_W-1:0] LastIter = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // mcand: multiplicand or divisor magnitude.
  // acc:   upper product half or partial remainder.
  // shreg: multiplier shifting out / quotient shifting in (lower product half).
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             is_div_q, is_div_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             dz_q, dz_d;
  logic             done_q, done_d;

  logic               start_ok;
  logic               is_signed_op, is_div_op;
  logic               x_neg, y_neg;
  logic [WIDTH-1:0]   x_mag, y_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift, div_diff;
  logic [2*WIDTH-1:0] prod_mag, prod_res;

  always_comb begin
    start_ok     = (state_q == StIdle) && MDStart && (MDOp != OpNone) && (MDOp != OpRsvd);
    is_signed_op = (MDOp == OpMult) || (MDOp == OpDiv);
    is_div_op    = (MDOp == OpDiv) || (MDOp == OpDivu);
    x_neg        = is_signed_op & MDOpX[WIDTH-1];
    y_neg        = is_signed_op & MDOpY[WIDTH-1];
    x_mag        = x_neg ? -MDOpX : MDOpX;
    y_mag        = y_neg ? -MDOpY : MDOpY;

    mul_sum   = {1'b0, acc_q} + (shreg_q[0] ? {1'b0, mcand_q} : '0);
    // Remainder stays below the divisor, so the shifted value fits in WIDTH+1 bits.
    div_shift = {acc_q, shreg_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, mcand_q};

    prod_mag  = {acc_q, shreg_q};
    prod_res  = qneg_q ? -prod_mag : prod_mag;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    shreg_d  = shreg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    is_div_d = is_div_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    done_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_ok) begin
          if (MDOp == OpMthi) begin
            hi_d   = MDOpX;
            done_d = 1'b1;
          end else if (MDOp == OpMtlo) begin
            lo_d   = MDOpX;
            done_d = 1'b1;
          end else begin
            state_d  = StRun;
            cnt_d    = '0;
            acc_d    = '0;
            is_div_d = is_div_op;
            qneg_d   = x_neg ^ y_neg;
            rneg_d   = is_div_op & x_neg;
            dz_d     = is_div_op && (MDOpY == '0);
            mcand_d  = is_div_op ? y_mag : x_mag;
            shreg_d  = is_div_op ? x_mag : y_mag;
          end
        end
      end

      StRun: begin
        cnt_d = cnt_q + 1'b1;
        if (is_div_q) begin
          if (!div_diff[WIDTH]) begin
            acc_d   = div_diff[WIDTH-1:0];
            shreg_d = {shreg_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d   = div_shift[WIDTH-1:0];
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          acc_d   = mul_sum[WIDTH:1];
          shreg_d = {mul_sum[0], shreg_q[WIDTH-1:1]};
        end
        if (cnt_q == LastIter) begin
          state_d = StFix;
        end
      end

      StFix: begin
        state_d = StIdle;
        done_d  = 1'b1;
        if (is_div_q) begin
          // Zero divisor leaves the dividend magnitude in acc; restoring its sign yields MDOpX.
          lo_d = dz_q ? '1 : (qneg_q ? -shreg_q : shreg_q);
          hi_d = rneg_q ? -acc_q : acc_q;
        end else begin
          {hi_d, lo_d} = prod_res;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      shreg_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div_q <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      shreg_q  <= shreg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      is_div_q <= is_div_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
      done_q   <= done_d;
    end
  end

  assign MDBusy = (state_q != StIdle);
  assign MDDone = done_q;
  assign HI     = hi_q;
  assign LO     = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized self-checking bench for mult_div_unit against a plain-arithmetic HI/LO model.
module tb_mult_div_unit;

  logic        clk;
  logic        rst;
  logic        MDStart;
  logic [2:0]  MDOp;
  logic [31:0] MDOpX;
  logic [31:0] MDOpY;
  logic        MDBusy;
  logic        MDDone;
  logic [31:0] HI;
  logic [31:0] LO;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_hi, exp_lo;

  mult_div_unit #(
    .WIDTH(32),
    .CNT_W(6)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .MDStart(MDStart),
    .MDOp   (MDOp),
    .MDOpX  (MDOpX),
    .MDOpY  (MDOpY),
    .MDBusy (MDBusy),
    .MDDone (MDDone),
    .HI     (HI),
    .LO     (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", tag, got, want, $time);
    end
  endtask

  // Reference: architectural HI/LO semantics using 64-bit arithmetic.
  task automatic ref_model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] xs, ys, q, r;
    logic [63:0] p;
    xs = longint'($signed(x));
    ys = longint'($signed(y));
    case (op)
      3'd1: begin p = xs * ys; {exp_hi, exp_lo} = p; end
      3'd2: begin p = {32'b0, x} * {32'b0, y}; {exp_hi, exp_lo} = p; end
      3'd3, 3'd4: begin
        if (y == 32'd0) begin
          exp_lo = 32'hFFFF_FFFF;
          exp_hi = x;
        end else if (op == 3'd3) begin
          q = xs / ys;
          r = xs % ys;
          exp_lo = q[31:0];
          exp_hi = r[31:0];
        end else begin
          exp_lo = x / y;
          exp_hi = x % y;
        end
      end
      3'd5: exp_hi = x;
      3'd6: exp_lo = x;
      default: ;
    endcase
  endtask

  // Called #1 after a rising edge; returns #1 after the done edge.
  task automatic run_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                        input bit poke);
    int lat, busy_cnt;
    bit hold_ok;
    logic [31:0] h0, l0;
    h0 = exp_hi;
    l0 = exp_lo;
    ref_model(op, x, y);
    MDStart = 1'b1;
    MDOp    = op;
    MDOpX   = x;
    MDOpY   = y;
    @(posedge clk); #1;
    MDStart = 1'b0;
    MDOp    = 3'd0;
    MDOpX   = $urandom;
    MDOpY   = $urandom;
    if (op == 3'd5 || op == 3'd6) begin
      check_eq("mt_done", {63'b0, MDDone}, 64'd1);
      check_eq("mt_busy", {63'b0, MDBusy}, 64'd0);
      check_eq("mt_hilo", {HI, LO}, {exp_hi, exp_lo});
    end else begin
      lat = 0;
      busy_cnt = 0;
      hold_ok = 1'b1;
      while (!MDDone && lat < 100) begin
        if (MDBusy) busy_cnt++;
        if (HI !== h0 || LO !== l0) hold_ok = 1'b0;
        if (poke && lat == 5) begin
          MDStart = 1'b1;
          MDOp    = 3'd2;
          MDOpX   = $urandom;
          MDOpY   = $urandom;
        end else begin
          MDStart = 1'b0;
        end
        @(posedge clk); #1;
        lat++;
      end
      MDStart = 1'b0;
      check_eq("latency", 64'(lat), 64'd33);
      check_eq("busy_cycles", 64'(busy_cnt), 64'd33);
      check_eq("hilo_hold", {63'b0, hold_ok}, 64'd1);
      check_eq("busy_at_done", {63'b0, MDBusy}, 64'd0);
      check_eq("result", {HI, LO}, {exp_hi, exp_lo});
    end
  endtask

  task automatic ignored_op(input logic [2:0] op);
    MDStart = 1'b1;
    MDOp    = op;
    MDOpX   = $urandom;
    MDOpY   = $urandom;
    @(posedge clk); #1;
    MDStart = 1'b0;
    check_eq("ign_done", {63'b0, MDDone}, 64'd0);
    check_eq("ign_busy", {63'b0, MDBusy}, 64'd0);
    check_eq("ign_hilo", {HI, LO}, {exp_hi, exp_lo});
  endtask

  logic [31:0] specials [6] = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'd7};

  function automatic logic [31:0] pick();
    if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  initial begin
    int done_seen;
    rst     = 1'b1;
    MDStart = 1'b0;
    MDOp    = 3'd0;
    MDOpX   = '0;
    MDOpY   = '0;
    exp_hi  = '0;
    exp_lo  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_state", {60'b0, MDBusy, MDDone, 2'b0}, 64'd0);
    check_eq("reset_hilo", {HI, LO}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases chained back to back: each start lands in the previous done cycle.
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(3'd1, -32'sd3, 32'd5, 1'b0);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 1'b0);
    run_op(3'd3, -32'sd7, 32'd2, 1'b0);
    run_op(3'd4, 32'd100, 32'd7, 1'b0);
    run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(3'd4, 32'd12345, 32'd0, 1'b0);
    run_op(3'd3, -32'sd12345, 32'd0, 1'b0);
    run_op(3'd5, 32'hDEAD_BEEF, 32'd0, 1'b0);
    run_op(3'd6, 32'h1234_5678, 32'd0, 1'b0);
    run_op(3'd2, 32'd1000, 32'd3000, 1'b1);
    @(posedge clk); #1;
    check_eq("done_pulse_width", {63'b0, MDDone}, 64'd0);
    check_eq("hilo_after_done", {HI, LO}, {exp_hi, exp_lo});

    ignored_op(3'd0);
    ignored_op(3'd7);

    // Reset mid-multiply: abort at once, no late done.
    MDStart = 1'b1;
    MDOp    = 3'd2;
    MDOpX   = 32'd7;
    MDOpY   = 32'd9;
    @(posedge clk); #1;
    MDStart = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    exp_hi = '0;
    exp_lo = '0;
    check_eq("rst_mid_busy", {63'b0, MDBusy}, 64'd0);
    check_eq("rst_mid_done", {63'b0, MDDone}, 64'd0);
    check_eq("rst_mid_hilo", {HI, LO}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    done_seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (MDDone) done_seen++;
    end
    check_eq("rst_no_done", 64'(done_seen), 64'd0);
    check_eq("rst_hilo_kept", {HI, LO}, 64'd0);

    for (int i = 0; i < 60; i++) begin
      run_op(3'($urandom_range(1, 6)), pick(), pick(), ($urandom_range(0, 4) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multi-cycle HI/LO arithmetic unit that runs beside the single-cycle ALU in the EX stage. It takes the same operand pair, ALUOpX and ALUOpY.
- Executes MIPS mult, multu, div, divu, mthi and mtlo. Results are held in internal HI/LO registers.
- The pipeline control uses MDBusy to stall any mfhi/mflo or new MD op until the unit is free. An iterative shift-add multiplier and a restoring divider keep the area small.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 6, iteration counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-high.
- MDStart  input  1  start request, sampled on the rising edge of clk.
- MDOp  input  3  operation select: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved.
- MDOpX  input  WIDTH  rs operand (multiplicand or dividend; source for mthi/mtlo).
- MDOpY  input  WIDTH  rt operand (multiplier or divisor).
- MDBusy  output  1  high while an iterative operation is in flight.
- MDDone  output  1  one-cycle pulse when HI/LO take new values.
- HI  output  WIDTH  HI register: product upper half or remainder.
- LO  output  WIDTH  LO register: product lower half or quotient.

Behaviour:
- Reset (async, rst=1): state=IDLE, MDBusy=0, MDDone=0, HI=0, LO=0, counter=0, internal datapath registers cleared.
  - Asserting reset mid-operation aborts the operation immediately; no partial result reaches HI/LO.
- State machine IDLE -> RUN -> FIX -> IDLE.
  - A start is accepted only in IDLE with MDStart=1 and MDOp in 1..6. Anything else is ignored, with no state change and no MDDone.
  - MDStart while MDBusy=1 is ignored; the in-flight operation is unaffected.
- mthi/mtlo: single cycle, no busy.
  - At the accepting edge, HI (or LO) <= MDOpX.
  - MDDone=1 for the following cycle.
  - The other register is unchanged.
- mult/multu/div/divu at accepting edge E0:
  - Latch operands. Signed ops store magnitudes plus result-sign flags.
  - counter <= 0, state <= RUN, MDBusy=1 from the cycle after E0.
- RUN: one iteration per cycle, edges E1..E32 (WIDTH iterations); counter increments each edge.
  - Multiply: 64-bit shift-add on magnitudes, one multiplier bit per cycle, LSB first.
  - Divide: restoring division, one quotient bit per cycle, MSB first. The partial remainder is WIDTH+1 bits wide so the trial subtract does not overflow.
  - When counter reaches WIDTH-1, the next edge moves to FIX.
- FIX at edge E33:
  - Apply sign correction and load HI/LO. state <= IDLE, MDBusy <= 0.
  - MDDone=1 for exactly the cycle after E33, so the result is visible 33 cycles after the accepting edge.
  - A new start may be accepted on the same edge MDDone is high.
- Sign and overflow rules:
  - mult: product negated if the operand signs differ; the result is the full 64-bit two's complement.
  - multu: plain unsigned product.
  - div: quotient negated if signs differ; remainder takes the sign of the dividend.
  - -2^31 / -1 gives LO=32'h80000000, HI=0 (wraps).
  - Results satisfy LO*Y + HI == X (mod 2^32) for every non-zero divisor.
- Divide by zero (div or divu):
  - Runs the full latency with no trap.
  - Result is LO=32'hFFFFFFFF and HI=MDOpX, exactly as latched, for both signed and unsigned.
- HI/LO hold their values between operations and change only at a done edge. MDDone never pulses without an HI/LO write.

Test Plan:
- Reset mid-multiply: multu 7x9 started, rst asserted at cycle 10 -> MDBusy=0, HI=LO=0 immediately, no MDDone.
- multu 32'hFFFFFFFF x 32'hFFFFFFFF -> after 33 cycles MDDone pulses once; HI=32'hFFFFFFFE, LO=32'h00000001; MDBusy high for exactly 33 cycles.
- mult -3 x 5 -> HI=32'hFFFFFFFF, LO=32'hFFFFFFF1. mult 32'h80000000 x 32'h80000000 -> HI=32'h40000000, LO=0.
- div -7 / 2 -> LO=32'hFFFFFFFD (-3), HI=32'hFFFFFFFF (-1). divu 100 / 7 -> LO=14, HI=2. div 32'h80000000 / -1 -> LO=32'h80000000, HI=0.
- Divide by zero: divu 12345 / 0 -> LO=32'hFFFFFFFF, HI=12345 after 33 cycles.
- Handshake:
  - mthi 32'hDEADBEEF -> HI updated next cycle, MDDone 1 cycle, MDBusy stays 0.
  - MDStart with multu asserted while busy -> ignored, original result intact.
  - Back-to-back start on the MDDone cycle -> accepted.
